// File: rtl/uart_tx_framer.sv
// UART transmitter: REQ/ACK word intake, bit-period divider and frame
// serialiser (start, data LSB first, optional parity, 1 or 2 stop bits).
//
// Ports:
//   CLK           clock
//   RST           synchronous active-high reset
//   TX_START_REQ  four-phase frame request
//   TX_DATA       word to send, sampled on the accept edge only
//   TX_START_ACK  handshake acknowledge
//   TX_BUSY       high whenever the framer is not IDLE
//   TX_DONE       one-cycle pulse on the first IDLE cycle after a frame
//   TXD           registered serial output, idles high
module uart_tx_framer #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TX_START_REQ,
    input  logic [DATA_BITS-1:0] TX_DATA,
    output logic                 TX_START_ACK,
    output logic                 TX_BUSY,
    output logic                 TX_DONE,
    output logic                 TXD
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int DIV_W =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [3:0]           bit_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic                 bit_end;

    assign bit_end = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            shreg        <= '0;
            par_bit      <= 1'b0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            TXD          <= 1'b1;
            TX_START_ACK <= 1'b0;
            TX_BUSY      <= 1'b0;
            TX_DONE      <= 1'b0;
        end else begin
            TX_DONE <= 1'b0;

            // ACK only falls once REQ has been seen low,
            // independent of where the frame is.
            if (TX_START_ACK && !TX_START_REQ)
                TX_START_ACK <= 1'b0;

            if (state == IDLE) begin
                if (TX_START_REQ && !TX_START_ACK) begin
                    shreg        <= TX_DATA;
                    par_bit      <= (PARITY == 1) ? ~^TX_DATA
                                                  : ^TX_DATA;
                    state        <= START;
                    TXD          <= 1'b0;
                    TX_START_ACK <= 1'b1;
                    TX_BUSY      <= 1'b1;
                    div_cnt      <= '0;
                    bit_cnt      <= '0;
                end
            end else if (!bit_end) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        TXD     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                TXD   <= par_bit;
                            end else begin
                                state <= STOP;
                                TXD   <= 1'b1;
                            end
                        end else begin
                            TXD     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PAR: begin
                        state   <= STOP;
                        TXD     <= 1'b1;
                        bit_cnt <= '0;
                    end
                    STOP: begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= IDLE;
                            TX_DONE <= 1'b1;
                            TX_BUSY <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        TXD     <= 1'b1;
                        TX_BUSY <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: 8N1, 8E1, 8O1 and 7E2/4 instances,
// handshake hold, mid-frame reset and data-stability checks.
module tb_uart_tx_framer;

    logic       CLK;
    logic       RST;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] txd;
    logic [7:0] data [3];
    logic [6:0] data7;

    int checks = 0;
    int errors = 0;

    uart_tx_framer #(
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(1)
    ) u_n (
        .CLK(CLK), .RST(RST),
        .TX_START_REQ(req[0]), .TX_DATA(data[0]),
        .TX_START_ACK(ack[0]), .TX_BUSY(busy[0]),
        .TX_DONE(done[0]), .TXD(txd[0])
    );

    uart_tx_framer #(
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(1)
    ) u_e (
        .CLK(CLK), .RST(RST),
        .TX_START_REQ(req[1]), .TX_DATA(data[1]),
        .TX_START_ACK(ack[1]), .TX_BUSY(busy[1]),
        .TX_DONE(done[1]), .TXD(txd[1])
    );

    uart_tx_framer #(
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(1)
    ) u_o (
        .CLK(CLK), .RST(RST),
        .TX_START_REQ(req[2]), .TX_DATA(data[2]),
        .TX_START_ACK(ack[2]), .TX_BUSY(busy[2]),
        .TX_DONE(done[2]), .TXD(txd[2])
    );

    uart_tx_framer #(
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(4)
    ) u_7 (
        .CLK(CLK), .RST(RST),
        .TX_START_REQ(req[3]), .TX_DATA(data7),
        .TX_START_ACK(ack[3]), .TX_BUSY(busy[3]),
        .TX_DONE(done[3]), .TXD(txd[3])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [7:0] d);
        if (k == 3) data7 = d[6:0];
        else data[k] = d;
    endtask

    // bits[0] is the start bit; one entry per bit slot.
    task automatic run_frame(input int k,
                             input string tag,
                             input logic [7:0] d,
                             input logic [15:0] bits,
                             input int nbits,
                             input int cpb);
        req[k] = 1'b1;
        set_data(k, d);
        step();
        chk({tag, " ack_rise"}, 32'(ack[k]), 1);
        chk({tag, " busy_rise"}, 32'(busy[k]), 1);
        req[k] = 1'b0;
        set_data(k, 8'hFF);
        for (int c = 0; c < nbits * cpb; c++) begin
            chk($sformatf("%s txd_c%0d", tag, c),
                32'(txd[k]), 32'(bits[c / cpb]));
            chk($sformatf("%s done_c%0d", tag, c),
                32'(done[k]), 0);
            step();
        end
        chk({tag, " done_pulse"}, 32'(done[k]), 1);
        chk({tag, " busy_end"}, 32'(busy[k]), 0);
        chk({tag, " txd_idle"}, 32'(txd[k]), 1);
        chk({tag, " ack_end"}, 32'(ack[k]), 0);
        step();
        chk({tag, " done_clear"}, 32'(done[k]), 0);
    endtask

    initial begin
        RST   = 1'b1;
        req   = '0;
        data7 = '0;
        for (int i = 0; i < 3; i++) data[i] = '0;
        step();
        step();
        chk("rst txd", 32'(txd), 32'hF);
        chk("rst ack", 32'(ack), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        RST = 1'b0;
        step();
        chk("post_rst txd", 32'(txd), 32'hF);

        // 0xA5 LSB first = 1,0,1,0,0,1,0,1
        run_frame(0, "8N1_A5", 8'hA5, 16'(10'b1_10100101_0), 10, 1);
        run_frame(1, "8E1_A5", 8'hA5, 16'(11'b1_0_10100101_0), 11, 1);
        run_frame(2, "8O1_A5", 8'hA5, 16'(11'b1_1_10100101_0), 11, 1);
        // 0x41 in 7 bits = 1000001, two ones -> even parity 0
        run_frame(3, "7E2_41", 8'h41, 16'(12'b11_0_1000001_0), 11, 4);

        // REQ held for 30 cycles: exactly one frame
        req[0]  = 1'b1;
        data[0] = 8'h5A;
        step();
        for (int c = 1; c < 30; c++) begin
            step();
            chk($sformatf("hold ack_c%0d", c), 32'(ack[0]), 1);
            chk($sformatf("hold busy_c%0d", c),
                32'(busy[0]), (c < 10) ? 1 : 0);
            chk($sformatf("hold done_c%0d", c),
                32'(done[0]), (c == 10) ? 1 : 0);
        end
        chk("hold txd", 32'(txd[0]), 1);
        req[0] = 1'b0;
        step();
        chk("hold ack_drop", 32'(ack[0]), 0);
        chk("hold busy_drop", 32'(busy[0]), 0);
        step();
        chk("hold ack_idle", 32'(ack[0]), 0);
        chk("hold busy_idle", 32'(busy[0]), 0);
        run_frame(0, "8N1_3C", 8'h3C, 16'(10'b1_00111100_0), 10, 1);

        // Reset during DATA bit 3 of 0xA5 (bit 3 = 0)
        req[0]  = 1'b1;
        data[0] = 8'hA5;
        step();
        for (int c = 0; c < 4; c++) step();
        chk("mid txd_bit3", 32'(txd[0]), 0);
        chk("mid busy", 32'(busy[0]), 1);
        chk("mid ack", 32'(ack[0]), 1);
        RST = 1'b1;
        step();
        chk("mid_rst txd", 32'(txd[0]), 1);
        chk("mid_rst ack", 32'(ack[0]), 0);
        chk("mid_rst busy", 32'(busy[0]), 0);
        chk("mid_rst done", 32'(done[0]), 0);
        RST    = 1'b0;
        req[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("mid_after done_c%0d", c), 32'(done[0]), 0);
            chk($sformatf("mid_after txd_c%0d", c), 32'(txd[0]), 1);
        end
        run_frame(0, "8N1_A5_rst", 8'hA5, 16'(10'b1_10100101_0), 10, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
